// File: rtl/multicycle_subtractor_64_pkg.sv
// Shared constants and FSM state type for the sliced 64-bit subtractor.
package multicycle_subtractor_64_pkg;
  localparam int unsigned DATA_W          = 64;
  localparam int unsigned DEFAULT_SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/multicycle_subtractor_64_subtract_slice.sv
// Combinational WIDTH-bit ripple-borrow subtract: d = a - b - bin.
module subtract_slice #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] d,
  output logic             bout
);
  logic [WIDTH:0] sum;

  // a + ~b + ~bin; the carry out is the inverted borrow.
  always_comb begin
    sum  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, ~bin};
    d    = sum[WIDTH-1:0];
    bout = ~sum[WIDTH];
  end
endmodule

// File: rtl/multicycle_subtractor_64.sv
// 64-bit subtractor D = A - B - BI, one SLICE_W-bit slice per cycle, valid/ready on both sides.
import multicycle_subtractor_64_pkg::*;

module multicycle_subtractor_64 #(
  parameter int unsigned SLICE_W = DEFAULT_SLICE_W
) (
  input  logic              in_CLK,
  input  logic              in_RST_N,
  input  logic              in_VALID,
  output logic              out_READY,
  input  logic [DATA_W-1:0] in_A,
  input  logic [DATA_W-1:0] in_B,
  input  logic              in_BI,
  output logic              out_VALID,
  input  logic              in_READY,
  output logic [DATA_W-1:0] out_D,
  output logic              out_BO,
  output logic              out_V,
  output logic              out_ZERO
);
  localparam int unsigned N   = DATA_W / SLICE_W;
  localparam int unsigned K_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [K_W-1:0]    K_LAST     = K_W'(N - 1);
  localparam logic [DATA_W-1:0] SLICE_MASK = {DATA_W{1'b1}} >> (DATA_W - SLICE_W);

  state_t            state;
  logic [K_W-1:0]    k;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;
  logic [DATA_W-1:0] d_r;
  logic              borrow;
  logic              ready_r;
  logic              valid_r;
  logic              bo_r;
  logic              v_r;
  logic              zero_r;

  logic [6:0]         shamt;
  logic [SLICE_W-1:0] sa;
  logic [SLICE_W-1:0] sb;
  logic [SLICE_W-1:0] sd;
  logic               sbout;
  logic [DATA_W-1:0]  d_next;

  // Full next difference is formed here so the flags can be taken on the last slice edge.
  always_comb begin
    shamt  = 7'(k) * 7'(SLICE_W);
    sa     = SLICE_W'(a_r >> shamt);
    sb     = SLICE_W'(b_r >> shamt);
    d_next = (d_r & ~(SLICE_MASK << shamt)) | (DATA_W'(sd) << shamt);
  end

  subtract_slice #(.WIDTH(SLICE_W)) u_slice (
    .a    (sa),
    .b    (sb),
    .bin  (borrow),
    .d    (sd),
    .bout (sbout)
  );

  always_ff @(posedge in_CLK or negedge in_RST_N) begin
    if (!in_RST_N) begin
      state   <= IDLE;
      k       <= '0;
      a_r     <= '0;
      b_r     <= '0;
      d_r     <= '0;
      borrow  <= 1'b0;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
      bo_r    <= 1'b0;
      v_r     <= 1'b0;
      zero_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_VALID) begin
            a_r     <= in_A;
            b_r     <= in_B;
            borrow  <= in_BI;
            k       <= '0;
            ready_r <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          d_r    <= d_next;
          borrow <= sbout;
          if (k == K_LAST) begin
            bo_r    <= sbout;
            v_r     <= (a_r[DATA_W-1] != b_r[DATA_W-1]) && (d_next[DATA_W-1] != a_r[DATA_W-1]);
            zero_r  <= (d_next == '0);
            valid_r <= 1'b1;
            state   <= DONE;
          end else begin
            k <= k + K_W'(1);
          end
        end
        DONE: begin
          if (in_READY) begin
            valid_r <= 1'b0;
            ready_r <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_READY = ready_r;
  assign out_VALID = valid_r;
  assign out_D     = d_r;
  assign out_BO    = bo_r;
  assign out_V     = v_r;
  assign out_ZERO  = zero_r;
endmodule

// File: tb/tb_multicycle_subtractor_64.sv
// Scoreboard bench: three DUT lanes (SLICE_W = 8, 1, 64) checked against an arithmetic reference model.
module tb_multicycle_subtractor_64;
  typedef struct {
    logic [63:0] d;
    logic        bo;
    logic        v;
    logic        zero;
    longint      due;
  } exp_t;

  logic   clk = 1'b0;
  longint cyc = 0;
  int     total = 0;
  int     bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: exact integer arithmetic, then wrap; overflow when the wrapped value misrepresents the exact signed result.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic bi);
    exp_t e;
    logic signed [65:0] s;
    e.d    = a - b - 64'(bi);
    e.bo   = ({1'b0, a} < ({1'b0, b} + 65'(bi)));
    s      = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b}) - $signed(66'(bi));
    e.v    = (s != $signed({{2{e.d[63]}}, e.d}));
    e.zero = (e.d == 64'd0);
    e.due  = 0;
    return e;
  endfunction

  task automatic chk(input string nm, input int sw, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s sw=%0d got=%0h want=%0h", nm, sw, act, expv);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int unsigned SW = (g == 0) ? 8 : ((g == 1) ? 1 : 64);
    localparam int unsigned N  = 64 / SW;

    logic        rst_n;
    logic        drv_valid, mon_valid, mon_ready;
    logic [63:0] drv_a, drv_b, mon_a, mon_b;
    logic        drv_bi, mon_bi;
    logic        in_valid, in_bi;
    logic [63:0] in_a, in_b;
    logic        out_ready, out_valid, out_bo, out_v, out_zero;
    logic [63:0] out_d;
    exp_t        q[$];
    bit          done = 1'b0;

    assign in_valid = drv_valid | mon_valid;
    assign in_a     = mon_valid ? mon_a : drv_a;
    assign in_b     = mon_valid ? mon_b : drv_b;
    assign in_bi    = mon_valid ? mon_bi : drv_bi;

    multicycle_subtractor_64 #(.SLICE_W(SW)) dut (
      .in_CLK    (clk),
      .in_RST_N  (rst_n),
      .in_VALID  (in_valid),
      .out_READY (out_ready),
      .in_A      (in_a),
      .in_B      (in_b),
      .in_BI     (in_bi),
      .out_VALID (out_valid),
      .in_READY  (mon_ready),
      .out_D     (out_d),
      .out_BO    (out_bo),
      .out_V     (out_v),
      .out_ZERO  (out_zero)
    );

    task automatic chk_reset(input string tag);
      chk({tag, "_rst_ready"}, SW, 64'(out_ready), 64'd1);
      chk({tag, "_rst_valid"}, SW, 64'(out_valid), 64'd0);
      chk({tag, "_rst_d"}, SW, out_d, 64'd0);
      chk({tag, "_rst_flags"}, SW, 64'({out_bo, out_v, out_zero}), 64'd0);
    endtask

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic bi, input bit push);
      int w = 0;
      exp_t e;
      @(negedge clk);
      while (!out_ready && w < 400) begin
        @(negedge clk);
        w++;
      end
      chk("accept_wait", SW, 64'(out_ready), 64'd1);
      drv_a = a; drv_b = b; drv_bi = bi; drv_valid = 1'b1;
      @(posedge clk);
      #1;
      drv_valid = 1'b0;
      if (push) begin
        e = model(a, b, bi);
        e.due = cyc + longint'(N);
        q.push_back(e);
      end
    endtask

    // While the operation runs, keep offering junk operands; they must not be taken.
    task automatic run_phase();
      for (int i = 0; i < int'(N) + 4; i++) begin
        @(negedge clk);
        if (out_valid) break;
        chk("ready_low_run", SW, 64'(out_ready), 64'd0);
        drv_valid = 1'($urandom_range(0, 1));
        drv_a = {$urandom, $urandom};
        drv_b = {$urandom, $urandom};
        drv_bi = 1'($urandom_range(0, 1));
      end
      drv_valid = 1'b0;
    endtask

    task automatic gen(output logic [63:0] a, output logic [63:0] b, output logic bi);
      int unsigned mode = $urandom_range(0, 3);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      bi = 1'($urandom_range(0, 1));
      case (mode)
        1: b = a;
        2: b = a - 64'($urandom_range(0, 2));
        3: begin a = 64'($urandom_range(0, 4)); b = 64'($urandom_range(0, 4)); end
        default: ;
      endcase
    endtask

    initial begin : drv
      logic [63:0] da [6];
      logic [63:0] db [6];
      logic        dbi [6];
      logic [63:0] ra, rb;
      logic        rbi;
      int          w;
      int unsigned abort_delay;
      da  = '{64'd5, 64'd0, 64'h8000_0000_0000_0000, 64'h0123_4567_89AB_CDEF,
              64'h0123_4567_89AB_CDEF, 64'h7FFF_FFFF_FFFF_FFFF};
      db  = '{64'd3, 64'd1, 64'd1, 64'h0123_4567_89AB_CDEF,
              64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF};
      dbi = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      drv_valid = 1'b0; drv_a = '0; drv_b = '0; drv_bi = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset("por");
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
        issue(da[i], db[i], dbi[i], 1'b1);
        run_phase();
      end
      for (int i = 0; i < 20; i++) begin
        gen(ra, rb, rbi);
        issue(ra, rb, rbi, 1'b1);
        run_phase();
      end

      // Abort an operation mid-flight; no result may ever appear for it.
      abort_delay = (N > 4) ? 4 : 0;
      gen(ra, rb, rbi);
      issue(ra, rb, rbi, 1'b0);
      repeat (abort_delay) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_reset("abort");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", SW, 64'(out_ready), 64'd1);
      chk("valid_after_rst", SW, 64'(out_valid), 64'd0);

      for (int i = 0; i < 3; i++) begin
        gen(ra, rb, rbi);
        issue(ra, rb, rbi, 1'b1);
        run_phase();
      end

      w = 0;
      while ((q.size() != 0 || !out_ready) && w < 400) begin
        @(negedge clk);
        w++;
      end
      chk("drained", SW, 64'(q.size()), 64'd0);
      done = 1'b1;
    end

    initial begin : mon
      exp_t e;
      int   stall;
      bit   first = 1'b1;
      mon_valid = 1'b0; mon_ready = 1'b0;
      mon_a = '0; mon_b = '0; mon_bi = 1'b0;
      forever begin
        @(negedge clk);
        if (rst_n && out_valid) begin
          chk("valid_expected", SW, 64'(q.size() != 0), 64'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("d", SW, out_d, e.d);
            chk("bo", SW, 64'(out_bo), 64'(e.bo));
            chk("v", SW, 64'(out_v), 64'(e.v));
            chk("zero", SW, 64'(out_zero), 64'(e.zero));
            chk("latency", SW, 64'(cyc), 64'(e.due));
            chk("ready_low_done", SW, 64'(out_ready), 64'd0);
            stall = first ? 5 : $urandom_range(0, 3);
            first = 1'b0;
            for (int i = 0; i < stall; i++) begin
              mon_valid = 1'($urandom_range(0, 1));
              mon_a = {$urandom, $urandom};
              mon_b = {$urandom, $urandom};
              mon_bi = 1'($urandom_range(0, 1));
              @(negedge clk);
              chk("hold_d", SW, out_d, e.d);
              chk("hold_flags", SW, 64'({out_valid, out_ready, out_bo, out_v, out_zero}),
                  64'({1'b1, 1'b0, e.bo, e.v, e.zero}));
            end
            mon_valid = 1'b0;
            mon_ready = 1'b1;
            @(posedge clk);
            #1;
            mon_ready = 1'b0;
            chk("consume", SW, 64'({out_valid, out_ready}), 64'b01);
          end
        end
      end
    end
  end

  initial begin
    fork
      wait (lane[0].done && lane[1].done && lane[2].done);
      #1_000_000;
    join_any
    disable fork;
    chk("all_lanes_done", 0, 64'({lane[0].done, lane[1].done, lane[2].done}), 64'b111);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
